// File: rtl/lfsr_pkg.sv
// -----------------------------------------------------------------------------
// lfsr_pkg
// Shared types and constants for the 5-bit Galois LFSR stream path.
//   LFSR_WIDTH      : default LFSR state width
//   lfsr_state_t    : one LFSR state word
//   period_state_e  : states of the period-measurement FSM
// -----------------------------------------------------------------------------
package lfsr_pkg;

    localparam int LFSR_WIDTH = 5;

    typedef logic [LFSR_WIDTH-1:0] lfsr_state_t;

    typedef enum logic [1:0] {
        IDLE,
        MEASURE,
        DONE
    } period_state_e;

endpackage : lfsr_pkg

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with registered occupancy and registered valid flag.
// The caller qualifies push/pop: push is never asserted when full, pop is
// never asserted when empty.
// Ports:
//   clk      : clock, all logic on posedge
//   rst      : synchronous active-high reset (flushes pointers and level)
//   push     : write wr_data at the tail
//   wr_data  : data to write
//   pop      : advance the head
//   rd_data  : head entry (valid when valid=1)
//   valid    : FIFO holds at least one entry (registered)
//   full     : FIFO holds DEPTH entries
//   level    : current occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       valid,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // NOTE: the storage array has no reset; only the pointers and level
    // define which entries are meaningful, so clearing the data would only
    // add reset fan-out.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            valid  <= 1'b0;
        end else begin
            // DEPTH is a power of two, so the pointers wrap on overflow.
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10: begin
                    level <= level + 1'b1;
                    valid <= 1'b1;
                end
                2'b01: begin
                    level <= level - 1'b1;
                    valid <= (level != LVL_W'(1));
                end
                default: ;  // idle or push+pop: occupancy unchanged
            endcase
        end
    end

    assign rd_data = mem[rd_ptr];
    assign full    = (level == LVL_W'(DEPTH));

endmodule : sync_fifo

// File: rtl/lfsr_stream_buffer.sv
// -----------------------------------------------------------------------------
// lfsr_stream_buffer
// Buffers accepted LFSR states in a small FIFO, back-pressures the generator
// through in_ready and measures the sequence period (pushes until the first
// captured value recurs).
// Ports:
//   clk          : clock, all logic on posedge
//   rst          : synchronous active-high reset
//   in_valid     : upstream offers a state
//   in_data      : current LFSR state
//   in_ready     : buffer accepts; LFSR step enable = in_valid & in_ready
//   out_valid    : head entry available
//   out_data     : head entry
//   out_ready    : consumer accepts head
//   level        : current occupancy
//   period       : measured period, meaningful when period_valid
//   period_valid : sticky, a period has been measured
//   no_period    : sticky, no recurrence within 2^WIDTH pushes
// -----------------------------------------------------------------------------
module lfsr_stream_buffer
    import lfsr_pkg::*;
#(
    parameter int WIDTH = LFSR_WIDTH,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [WIDTH-1:0]       in_data,
    output logic                   in_ready,
    output logic                   out_valid,
    output logic [WIDTH-1:0]       out_data,
    input  logic                   out_ready,
    output logic [$clog2(DEPTH):0] level,
    output logic [WIDTH:0]         period,
    output logic                   period_valid,
    output logic                   no_period
);

    // Number of states a WIDTH-bit register can visit.
    localparam logic [WIDTH:0] SPAN = {1'b1, {WIDTH{1'b0}}};

    logic          fifo_full;
    logic          push;
    logic          pop;

    period_state_e state;
    logic [WIDTH-1:0] ref_val;
    logic [WIDTH:0]   cnt;
    logic [WIDTH:0]   cnt_inc;

    // No full-bypass: a same-cycle pop does not free a slot for a push.
    assign in_ready = !rst && !fifo_full;
    assign push     = in_valid && in_ready;
    assign pop      = out_valid && out_ready;
    assign cnt_inc  = cnt + 1'b1;

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .wr_data (in_data),
        .pop     (pop),
        .rd_data (out_data),
        .valid   (out_valid),
        .full    (fifo_full),
        .level   (level)
    );

    // Period FSM: advanced by pushes only; DONE holds until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            ref_val      <= '0;
            cnt          <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            no_period    <= 1'b0;
        end else if (push) begin
            case (state)
                IDLE: begin
                    ref_val <= in_data;
                    cnt     <= '0;
                    state   <= MEASURE;
                end
                MEASURE: begin
                    if (in_data == ref_val) begin
                        period       <= cnt_inc;
                        period_valid <= 1'b1;
                        state        <= DONE;
                    end else if (cnt_inc == SPAN) begin
                        no_period <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                default: ;  // DONE: ignore further pushes
            endcase
        end
    end

endmodule : lfsr_stream_buffer

// File: tb/tb_lfsr_stream_buffer.sv
// -----------------------------------------------------------------------------
// tb_lfsr_stream_buffer
// Self-checking bench for lfsr_stream_buffer. A queue-based reference model
// tracks FIFO contents and the history of accepted pushes since reset; the
// expected period flags are derived from that history by searching for the
// first recurrence of the first pushed value.
// -----------------------------------------------------------------------------
module tb_lfsr_stream_buffer;
    import lfsr_pkg::*;

    localparam int WIDTH = LFSR_WIDTH;
    localparam int DEPTH = 4;
    localparam int SPAN  = 1 << WIDTH;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   in_valid;
    logic [WIDTH-1:0]       in_data;
    logic                   in_ready;
    logic                   out_valid;
    logic [WIDTH-1:0]       out_data;
    logic                   out_ready;
    logic [$clog2(DEPTH):0] level;
    logic [WIDTH:0]         period;
    logic                   period_valid;
    logic                   no_period;

    always #5 clk = ~clk;

    lfsr_stream_buffer #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_ready    (out_ready),
        .level        (level),
        .period       (period),
        .period_valid (period_valid),
        .no_period    (no_period)
    );

    // Reference model state
    lfsr_state_t q[$];      // FIFO contents, head at index 0
    lfsr_state_t hist[$];   // accepted pushes since reset (first SPAN+1)
    bit          last_push;
    int          total = 0;
    int          bad   = 0;

    function automatic lfsr_state_t lfsr_next(lfsr_state_t s);
        return s[0] ? ((s >> 1) ^ 5'h14) : (s >> 1);
    endfunction

    // Period k is the push index (counted from the reference push) at which
    // the first value reappears; giving up after SPAN further pushes.
    function automatic void period_model(output bit pv, output int per, output bit np);
        pv  = 1'b0;
        per = 0;
        np  = 1'b0;
        for (int k = 1; k < hist.size(); k++) begin
            if (hist[k] == hist[0]) begin
                pv  = 1'b1;
                per = k;
                return;
            end
            if (k == SPAN) begin
                np = 1'b1;
                return;
            end
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock: check outputs at the falling edge, then update the model
    // with what the rising edge must have done, then let inputs change.
    task automatic cycle();
        bit push;
        bit pop;
        bit pv;
        bit np;
        int per;
        @(negedge clk);
        chk("in_ready", 32'(in_ready), 32'(!rst && q.size() < DEPTH));
        chk("level", 32'(level), 32'(q.size()));
        chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
        if (q.size() != 0) chk("out_data", 32'(out_data), 32'(q[0]));
        period_model(pv, per, np);
        chk("period_valid", 32'(period_valid), 32'(pv));
        chk("period", 32'(period), 32'(per));
        chk("no_period", 32'(no_period), 32'(np));
        @(posedge clk);
        push = !rst && in_valid && (q.size() < DEPTH);
        pop  = !rst && out_ready && (q.size() != 0);
        last_push = push;
        if (rst) begin
            q.delete();
            hist.delete();
        end else begin
            if (pop) void'(q.pop_front());
            if (push) begin
                q.push_back(in_data);
                if (hist.size() <= SPAN) hist.push_back(in_data);
            end
        end
        #1;
    endtask

    initial begin
        lfsr_state_t s;
        lfsr_state_t fill_vals[4];
        fill_vals = '{5'h01, 5'h14, 5'h0A, 5'h05};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        last_push = 1'b0;

        // Reset: first edge establishes state, then two checked reset cycles
        @(posedge clk);
        #1;
        cycle();
        cycle();
        rst = 1'b0;
        cycle();
        chk("ready_after_reset", 32'(in_ready), 32'd1);

        // Single push with a one-cycle latency, then pop
        in_valid = 1'b1;
        in_data  = 5'h01;
        cycle();
        in_valid = 1'b0;
        chk("single_latency_valid", 32'(out_valid), 32'd1);
        chk("single_latency_data", 32'(out_data), 32'h01);
        cycle();
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
        cycle();

        // Fill, refuse when full, pop one, then drain in order
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = fill_vals[i];
            cycle();
        end
        chk("full_level", 32'(level), 32'd4);
        in_data = 5'h12;
        cycle();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
        cycle();
        chk("ready_after_pop", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) cycle();
        out_ready = 1'b0;

        // Simultaneous push and pop at level 2
        in_valid = 1'b1;
        in_data  = 5'h03;
        cycle();
        in_data  = 5'h09;
        cycle();
        in_data   = 5'h07;
        out_ready = 1'b1;
        cycle();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("pushpop_level", 32'(level), 32'd2);
        cycle();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) cycle();

        // Period of the real 5-bit LFSR, stepped by in_ready
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        s = 5'h01;
        out_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            in_valid = 1'b1;
            in_data  = s;
            cycle();
            if (last_push) s = lfsr_next(s);
        end
        in_valid = 1'b0;
        cycle();
        chk("lfsr_period", 32'(period), 32'd31);
        chk("lfsr_period_valid", 32'(period_valid), 32'd1);
        chk("lfsr_no_period", 32'(no_period), 32'd0);

        // No recurrence: 1..31, 0, then one more non-matching value
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        for (int i = 1; i <= 33; i++) begin
            in_valid = 1'b1;
            in_data  = (i <= 31) ? WIDTH'(i) : ((i == 32) ? 5'h00 : 5'h02);
            cycle();
        end
        in_valid = 1'b0;
        cycle();
        chk("nop_no_period", 32'(no_period), 32'd1);
        chk("nop_period_valid", 32'(period_valid), 32'd0);

        // Reset mid-run with level 3; the offered push is lost
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = WIDTH'(5 + i);
            cycle();
        end
        chk("pre_reset_level", 32'(level), 32'd3);
        rst = 1'b1;
        cycle();
        rst      = 1'b0;
        in_valid = 1'b0;
        chk("midreset_level", 32'(level), 32'd0);
        chk("midreset_out_valid", 32'(out_valid), 32'd0);
        chk("midreset_no_period", 32'(no_period), 32'd0);
        cycle();

        // Randomised traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            rst       = ($urandom_range(0, 79) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            in_data   = WIDTH'($urandom_range(0, 7));
            cycle();
        end
        rst      = 1'b0;
        in_valid = 1'b0;
        cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_lfsr_stream_buffer
